// File: rtl/rob_commit_unit_if.sv
// Signal bundle between dispatch/execute/register-file logic and rob_commit_unit.
// Names match the headTailROB-facing ports so the wiring reads one-to-one.
interface rob_commit_unit_if #(
  parameter int ROBsize     = 8,
  parameter int addrSize    = $clog2(ROBsize),
  parameter int dataWidth   = 32,
  parameter int regAddrSize = 5
);
  // head/tail pointers from headTailROB
  logic [addrSize-1:0]    head_i;
  logic [addrSize-1:0]    tail_i;
  logic                   tailReset_i;

  // dispatch allocation
  logic                   alloc_i;
  logic [regAddrSize-1:0] allocDest_i;
  logic                   allocStall_o;
  logic [addrSize-1:0]    allocTag_o;

  // out-of-order completion by tag
  logic                   complete_i;
  logic [addrSize-1:0]    completeTag_i;
  logic [dataWidth-1:0]   completeData_i;

  // in-order commit to the register file
  logic                   commitValid_o;
  logic                   rfReady_i;
  logic [regAddrSize-1:0] commitDest_o;
  logic [dataWidth-1:0]   commitData_o;
  logic [addrSize-1:0]    commitTag_o;
  logic                   updateHead_o;

  logic [addrSize:0]      count_o;

  modport slave (
    input  head_i, tail_i, tailReset_i,
    input  alloc_i, allocDest_i,
    output allocStall_o, allocTag_o,
    input  complete_i, completeTag_i, completeData_i,
    output commitValid_o,
    input  rfReady_i,
    output commitDest_o, commitData_o, commitTag_o, updateHead_o,
    output count_o
  );

  modport master (
    output head_i, tail_i, tailReset_i,
    output alloc_i, allocDest_i,
    input  allocStall_o, allocTag_o,
    output complete_i, completeTag_i, completeData_i,
    input  commitValid_o,
    output rfReady_i,
    input  commitDest_o, commitData_o, commitTag_o, updateHead_o,
    input  count_o
  );
endinterface

// File: rtl/rob_commit_unit.sv
// ROB entry payload store with in-order retire beside headTailROB.
// Define ROB_COMMIT_BYPASS_EN to let a completion at the head commit in the same cycle.
module rob_commit_unit #(
  parameter int ROBsize     = 8,
  parameter int addrSize    = $clog2(ROBsize),
  parameter int dataWidth   = 32,
  parameter int regAddrSize = 5
) (
  input logic              clk_i,
  input logic              reset_i,
  rob_commit_unit_if.slave rob
);

  localparam logic [addrSize:0] ROB_FULL = (addrSize+1)'(ROBsize);

  function automatic logic [addrSize-1:0] next_slot(input logic [addrSize-1:0] s);
    if (s == addrSize'(ROBsize-1)) return '0;
    return s + addrSize'(1);
  endfunction

  logic [ROBsize-1:0]     valid_q, valid_d;
  logic [ROBsize-1:0]     done_q, done_d;
  logic [regAddrSize-1:0] dest_q [ROBsize];
  logic [regAddrSize-1:0] dest_d [ROBsize];
  logic [dataWidth-1:0]   data_q [ROBsize];
  logic [dataWidth-1:0]   data_d [ROBsize];
  logic [addrSize:0]      count_q, count_d;

  logic                   alloc_stall;
  logic                   alloc_acc;
  logic [addrSize-1:0]    alloc_tag;
  logic                   comp_acc;
  logic                   bypass_hit;
  logic                   commit_valid;
  logic                   update_head;
  logic [dataWidth-1:0]   head_data;

  // Allocation: same stall term as headTailROB so both agree on acceptance.
  always_comb begin
    alloc_tag   = rob.tailReset_i ? next_slot(rob.tail_i) : '0;
    alloc_stall = rob.alloc_i & rob.tailReset_i & (next_slot(rob.tail_i) == rob.head_i);
    alloc_acc   = rob.alloc_i & ~alloc_stall;
  end

  // Only a live, not-yet-done slot may be completed; anything else is dropped.
  always_comb begin
    comp_acc = rob.complete_i & valid_q[rob.completeTag_i] & ~done_q[rob.completeTag_i];
  end

`ifdef ROB_COMMIT_BYPASS_EN
  always_comb begin
    bypass_hit = comp_acc & (rob.completeTag_i == rob.head_i);
  end
`else
  always_comb begin
    bypass_hit = 1'b0;
  end
`endif

  // Commit handshake: a transfer happens on any edge where commitValid_o and
  // rfReady_i are both 1; while valid is high without ready, all commit
  // outputs hold because the head entry and head_i cannot change.
  always_comb begin
    commit_valid = (valid_q[rob.head_i] & done_q[rob.head_i]) | bypass_hit;
    update_head  = commit_valid & rob.rfReady_i;
    head_data    = bypass_hit ? rob.completeData_i : data_q[rob.head_i];
  end

  // Entry state update: allocation, completion and retire always hit distinct
  // slots, except a bypassed head completion, where the retire clear wins.
  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    dest_d  = dest_q;
    data_d  = data_q;
    if (alloc_acc) begin
      valid_d[alloc_tag] = 1'b1;
      done_d[alloc_tag]  = 1'b0;
      dest_d[alloc_tag]  = rob.allocDest_i;
    end
    if (comp_acc) begin
      done_d[rob.completeTag_i] = 1'b1;
      data_d[rob.completeTag_i] = rob.completeData_i;
    end
    if (update_head) begin
      valid_d[rob.head_i] = 1'b0;
      done_d[rob.head_i]  = 1'b0;
    end
  end

  always_comb begin
    count_d = count_q;
    if (alloc_acc && !update_head && (count_q < ROB_FULL)) begin
      count_d = count_q + (addrSize+1)'(1);
    end else if (!alloc_acc && update_head && (count_q != '0)) begin
      count_d = count_q - (addrSize+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= '0;
      done_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

  // Payload is qualified by valid/done, so it needs no reset.
  always_ff @(posedge clk_i) begin
    dest_q <= dest_d;
    data_q <= data_d;
  end

  always_comb begin
    rob.allocStall_o  = alloc_stall;
    rob.allocTag_o    = alloc_tag;
    rob.commitValid_o = commit_valid;
    rob.updateHead_o  = update_head;
    rob.commitDest_o  = commit_valid ? dest_q[rob.head_i] : '0;
    rob.commitData_o  = commit_valid ? head_data : '0;
    rob.commitTag_o   = commit_valid ? rob.head_i : '0;
    rob.count_o       = count_q;
  end

endmodule

// File: doc/rob_commit_unit.md
# rob_commit_unit

- Holds the ROB entry payload (valid, done, destination register, result) and retires entries in program order.
- Sits beside `headTailROB`:
  - It consumes that block's `head_o`, `tail_o` and `tailReset_o`.
  - It drives that block's `updateHead_i` from `updateHead_o`.
- Dispatch allocates entries at the tail and execution units complete them out of order by tag.
- Completed head entries are handed to the register file through a valid/ready commit handshake.

## Interface

- `ROBsize`, default 8: number of ROB entries; must match `headTailROB`.
- `addrSize`, default `$clog2(ROBsize)`: tag/pointer width.
- `dataWidth`, default 32: result width.
- `regAddrSize`, default 5: architectural destination register width.

Reset is synchronous and active-high.

- `clk_i` input 1: the single clock.
- `reset_i` input 1: synchronous, active-high.
- `head_i` input addrSize: oldest entry, from `headTailROB.head_o`.
- `tail_i` input addrSize: last allocated entry, from `headTailROB.tail_o`.
- `tailReset_i` input 1: from `headTailROB.tailReset_o`; 0 means nothing has been allocated since reset.
- `alloc_i` input 1: dispatch allocation; the same signal drives `headTailROB.updateTail_i`.
- `allocDest_i` input regAddrSize: destination register of the allocated entry.
- `allocStall_o` output 1: allocation refused because the ROB is full.
- `allocTag_o` output addrSize: slot the allocation targets, for tagging the instruction.
- `complete_i` input 1: execution result valid.
- `completeTag_i` input addrSize: ROB slot being completed.
- `completeData_i` input dataWidth: result value.
- `commitValid_o` output 1: head entry is ready to retire.
- `rfReady_i` input 1: register file accepts the commit.
- `commitDest_o` output regAddrSize: destination of the retiring entry.
- `commitData_o` output dataWidth: value of the retiring entry.
- `commitTag_o` output addrSize: slot of the retiring entry; equals `head_i`.
- `updateHead_o` output 1: retire fires; connects to `headTailROB.updateHead_i`.
- `count_o` output addrSize+1: number of valid entries.

## Operation

**Per-entry state**
- Registers: `valid`, `done`, `dest`, `data`.

**Allocation slot**
- `allocTag_o` = `tailReset_i ? tail_i+1 : 0`, modulo ROBsize.

**Allocation stall and accept**
- `allocStall_o` = `alloc_i & tailReset_i & (tail_i+1 == head_i)`.
  - This is identical to the `headTailROB` stall term, so the two blocks never disagree on acceptance.
- Allocation is accepted when `alloc_i & ~allocStall_o`.
- On accept, the slot is written at the edge: `valid=1`, `done=0`, `dest=allocDest_i`.

**Completion**
- Completion is accepted when `complete_i & valid[completeTag_i] & ~done[completeTag_i]`.
- On accept: `done=1`, `data=completeData_i`.
- Completion to an invalid or already-done slot is ignored and no state changes.

**Commit**
- `commitValid_o` = `valid[head_i] & done[head_i]`. This is combinational.
- `commitDest_o`, `commitData_o` and `commitTag_o` are driven from entry `head_i`.
  - When `commitValid_o`=0 they are driven to 0.
- `updateHead_o` = `commitValid_o & rfReady_i`.
- At the edge where `updateHead_o`=1, `valid[head_i]` and `done[head_i]` are cleared.

**Occupancy**
- `count_o` increments on accepted allocation and decrements on `updateHead_o`.
- When both happen in one cycle, `count_o` is unchanged.
- `count_o` saturates at ROBsize; it never exceeds ROBsize and never goes below 0.

## Timing

- Reset, at the edge: all `valid`/`done` are 0 and `count_o`=0.
  - Consequently `commitValid_o`, `updateHead_o` and the commit data outputs are 0.
  - `allocStall_o` and `allocTag_o` follow their inputs combinationally.
- Reset asserted mid-operation discards all entries and any in-flight handshake at that edge.
- Allocate to complete: at least 1 cycle (the entry is valid from the edge after allocation).
  - A completion in the same cycle as the allocation of that slot is ignored.
- Complete to commit:
  - 1 cycle by default (`commitValid_o` rises the cycle after the completing edge).
  - 0 cycles with bypass enabled (see Configuration).
- Commit throughput is one entry per cycle.
  - `head_i` advances at the same edge the entry is cleared, so back-to-back commits are legal.
  - A commit is never issued twice for one slot.
- Handshake: while `commitValid_o`=1 and `rfReady_i`=0, all commit outputs hold stable.
- Simultaneous events:
  - Allocation, completion and commit in one cycle proceed independently; they always touch distinct slots.
  - Wrap-around of tags and `head_i` is modulo ROBsize.

## Configuration

- `ROB_COMMIT_BYPASS_EN` defined:
  - When `complete_i` targets `head_i`, is accepted, and the head entry is valid and not done, `commitValid_o`=1 in that same cycle.
  - `commitData_o` is then `completeData_i`.
  - If `rfReady_i`=1, the entry retires at that edge without ever setting `done`.
- `ROB_COMMIT_BYPASS_EN` undefined: commit sees only registered `done`/`data` (1-cycle complete-to-commit).

## Test plan

The bench instantiates `headTailROB` wired to this block: `alloc_i` drives `updateTail_i`, and `updateHead_o` drives `updateHead_i`.

1. Reset; alloc dest 3 -> `allocTag_o`=0, `count_o`=1; complete tag 0, data 0xAA -> next cycle `commitValid_o`=1, `commitDest_o`=3, `commitData_o`=0xAA, `updateHead_o`=1 (`rfReady_i`=1), `count_o`=0 after that edge.
2. Alloc slots 0,1,2; complete 2 then 1 -> `commitValid_o` stays 0; complete 0 -> commits tags 0,1,2 on three consecutive cycles.
3. Head done with `rfReady_i`=0 for 4 cycles -> `commitValid_o`=1 with stable data, `updateHead_o`=0; raise `rfReady_i` -> a single commit.
4. 8 allocs -> `count_o`=8; 9th alloc with `tail_i`=7, `head_i`=0 -> `allocStall_o`=1, `count_o` stays 8, no entry overwritten.
5. Complete head tag 0 with 0x55 -> with macro: commit in the same cycle, data 0x55; without macro: commit the next cycle; duplicate completion of a done slot is ignored.
6. Assert `reset_i` with 5 entries valid and a commit pending -> after that edge `count_o`=0, `commitValid_o`=0, `updateHead_o`=0.
